// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Cache-side and RAM-side bus bundle for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
  // instruction cache port
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  // data cache port
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  // single-port RAM
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  // arbiter side
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  // caches and RAM side
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Merges icache/dcache requests onto a single-port RAM with
//               data priority and retry on RAM error. Optional instruction
//               anti-starvation enabled by defining MEM_ARB_FAIR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_IGNT  = 2'd1;
  localparam logic [1:0] c_DGNT  = 2'd2;
  localparam logic [1:0] c_RETRY = 2'd3;

  localparam logic [1:0] c_RAM_ACCESS = 2'd2;
  localparam logic [1:0] c_RAM_ERROR  = 2'd3;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_starve_limit_range
    $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       r_retry_d;
  logic       w_dreq;
  logic       w_icpl;
  logic       w_dcpl;
  logic       w_fair_force;

  assign w_dreq = bus.dREN | bus.dWEN;
  assign w_icpl = (r_state == c_IGNT) && bus.iREN && (bus.ramstate == c_RAM_ACCESS);
  assign w_dcpl = (r_state == c_DGNT) && w_dreq && (bus.ramstate == c_RAM_ACCESS);

`ifdef MEM_ARB_FAIR_EN
  localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve;

  // Counts data completions that overtook a waiting fetch; saturates at 15.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_starve <= 4'd0;
    end else if (!bus.iREN || w_icpl) begin
      r_starve <= 4'd0;
    end else if (w_dcpl && (r_starve != 4'hF)) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  assign w_fair_force = bus.iREN && (r_starve >= c_STARVE_LIMIT);
`else
  assign w_fair_force = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_fair_force)  w_next = c_IGNT;
        else if (w_dreq)   w_next = c_DGNT;
        else if (bus.iREN) w_next = c_IGNT;
      end
      c_IGNT: begin
        if (!bus.iREN)                          w_next = c_IDLE;
        else if (bus.ramstate == c_RAM_ERROR)   w_next = c_RETRY;
        else if (bus.ramstate == c_RAM_ACCESS)  w_next = c_IDLE;
      end
      c_DGNT: begin
        if (!w_dreq)                            w_next = c_IDLE;
        else if (bus.ramstate == c_RAM_ERROR)   w_next = c_RETRY;
        else if (bus.ramstate == c_RAM_ACCESS)  w_next = c_IDLE;
      end
      c_RETRY: w_next = r_retry_d ? c_DGNT : c_IGNT;
      default: w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= c_IDLE;
      r_retry_d <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == c_RETRY) r_retry_d <= (r_state == c_DGNT);
    end
  end

  // RAM side is a live mux of whichever port holds the grant.
  always_comb begin
    bus.iwait    = 1'b1;
    bus.iload    = 32'd0;
    bus.dwait    = 1'b1;
    bus.dload    = 32'd0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'd0;
    bus.ramstore = 32'd0;
    case (r_state)
      c_IGNT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        if (w_icpl) begin
          bus.iwait = 1'b0;
          bus.iload = bus.ramload;
        end
      end
      c_DGNT: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (w_dcpl) begin
          bus.dwait = 1'b0;
          bus.dload = bus.ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed scenarios plus randomized caches/RAM traffic checked
//               against a golden memory image for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam logic [1:0] c_FREE   = 2'd0;
  localparam logic [1:0] c_BUSY   = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;
  localparam logic [1:0] c_ERROR  = 2'd3;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(2)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ram(input logic [1:0] st, input logic [31:0] ld);
    bus.ramstate = st;
    bus.ramload  = ld;
  endtask

  // golden image as seen by the caches vs. contents of the modelled RAM
  logic [31:0] gold [16];
  logic [31:0] rmem [16];

  int i_cnt, d_cnt, d_before, ic, dc;
  int i_age, d_age, lat;
  bit i_act, d_act;

  initial begin
    bus.iREN = 1'b0; bus.iaddr = 32'd0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'd0; bus.dstore = 32'd0;
    set_ram(c_FREE, 32'hFFFF_FFFF);

    // ---------------- reset values ----------------
    #12;
    check_eq("rst_iwait",    32'(bus.iwait),  32'd1);
    check_eq("rst_dwait",    32'(bus.dwait),  32'd1);
    check_eq("rst_iload",    bus.iload,       32'd0);
    check_eq("rst_dload",    bus.dload,       32'd0);
    check_eq("rst_ramREN",   32'(bus.ramREN), 32'd0);
    check_eq("rst_ramWEN",   32'(bus.ramWEN), 32'd0);
    check_eq("rst_ramaddr",  bus.ramaddr,     32'd0);
    check_eq("rst_ramstore", bus.ramstore,    32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    adv();

    // ---------------- lone fetch ----------------
    bus.iREN = 1'b1; bus.iaddr = 32'h40; set_ram(c_FREE, 32'd0);
    settle();
    check_eq("fetch_no_comb_path", 32'(bus.ramREN), 32'd0);
    adv(); set_ram(c_BUSY, 32'h0BAD_0BAD); settle();
    check_eq("fetch_ramREN",  32'(bus.ramREN), 32'd1);
    check_eq("fetch_ramWEN",  32'(bus.ramWEN), 32'd0);
    check_eq("fetch_ramaddr", bus.ramaddr,     32'h40);
    check_eq("fetch_busy_iwait", 32'(bus.iwait), 32'd1);
    check_eq("fetch_busy_iload", bus.iload,      32'd0);
    adv(); set_ram(c_BUSY, 32'h0BAD_0BAD); settle();
    check_eq("fetch_busy2_iwait", 32'(bus.iwait), 32'd1);
    adv(); set_ram(c_ACCESS, 32'hDEAD_BEEF); settle();
    check_eq("fetch_done_iwait", 32'(bus.iwait), 32'd0);
    check_eq("fetch_done_iload", bus.iload,      32'hDEAD_BEEF);
    adv(); bus.iREN = 1'b0; set_ram(c_FREE, 32'hDEAD_BEEF); settle();
    check_eq("fetch_after_iwait",  32'(bus.iwait),  32'd1);
    check_eq("fetch_after_iload",  bus.iload,       32'd0);
    check_eq("fetch_after_ramREN", 32'(bus.ramREN), 32'd0);

    // ---------------- i/d collision ----------------
    adv();
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
    settle();
    check_eq("coll_idle_ramWEN", 32'(bus.ramWEN), 32'd0);
    adv(); set_ram(c_ACCESS, 32'd0); settle();
    check_eq("coll_ramWEN",   32'(bus.ramWEN), 32'd1);
    check_eq("coll_ramREN",   32'(bus.ramREN), 32'd0);
    check_eq("coll_ramaddr",  bus.ramaddr,     32'h80);
    check_eq("coll_ramstore", bus.ramstore,    32'h1234);
    check_eq("coll_dwait",    32'(bus.dwait),  32'd0);
    check_eq("coll_iwait",    32'(bus.iwait),  32'd1);
    adv(); bus.dWEN = 1'b0; set_ram(c_FREE, 32'd0); settle();
    check_eq("coll_gap_ramREN", 32'(bus.ramREN), 32'd0);
    check_eq("coll_gap_ramWEN", 32'(bus.ramWEN), 32'd0);
    check_eq("coll_gap_iwait",  32'(bus.iwait),  32'd1);
    adv(); set_ram(c_ACCESS, 32'hCAFE_F00D); settle();
    check_eq("coll_i_ramREN",  32'(bus.ramREN), 32'd1);
    check_eq("coll_i_ramaddr", bus.ramaddr,     32'h44);
    check_eq("coll_i_iwait",   32'(bus.iwait),  32'd0);
    check_eq("coll_i_iload",   bus.iload,       32'hCAFE_F00D);
    adv(); bus.iREN = 1'b0; set_ram(c_FREE, 32'd0);

    // ---------------- error retry ----------------
    bus.dREN = 1'b1; bus.daddr = 32'h90;
    adv(); set_ram(c_ERROR, 32'h0); settle();
    check_eq("err_ramREN", 32'(bus.ramREN), 32'd1);
    check_eq("err_dwait",  32'(bus.dwait),  32'd1);
    adv(); set_ram(c_FREE, 32'h0); settle();
    check_eq("retry_ramREN", 32'(bus.ramREN), 32'd0);
    check_eq("retry_dwait",  32'(bus.dwait),  32'd1);
    adv(); set_ram(c_ACCESS, 32'h5555_AAAA); settle();
    check_eq("reissue_ramREN",  32'(bus.ramREN), 32'd1);
    check_eq("reissue_ramaddr", bus.ramaddr,     32'h90);
    check_eq("reissue_dwait",   32'(bus.dwait),  32'd0);
    check_eq("reissue_dload",   bus.dload,       32'h5555_AAAA);
    adv(); bus.dREN = 1'b0; set_ram(c_FREE, 32'h0);

    // ---------------- fetch redirect ----------------
    bus.iREN = 1'b1; bus.iaddr = 32'h48;
    adv(); set_ram(c_BUSY, 32'h0); settle();
    check_eq("redir_ramREN", 32'(bus.ramREN), 32'd1);
    adv(); bus.iREN = 1'b0; settle();
    check_eq("redir_drop_iwait", 32'(bus.iwait), 32'd1);
    adv(); settle();
    check_eq("redir_next_ramREN", 32'(bus.ramREN), 32'd0);
    check_eq("redir_next_iwait",  32'(bus.iwait),  32'd1);
    adv(); settle();
    check_eq("redir_stay_ramREN", 32'(bus.ramREN), 32'd0);

    // ---------------- fairness / strict priority ----------------
    bus.iREN = 1'b1; bus.iaddr = 32'h4C;
    bus.dREN = 1'b1; bus.daddr = 32'h94;
    set_ram(c_ACCESS, 32'h1111);
    ic = 0; dc = 0; d_before = 0;
    for (int k = 0; k < 8; k++) begin
      settle();
      if (!bus.iwait) ic++;
      if (!bus.dwait) begin
        dc++;
        if (ic == 0) d_before++;
      end
      adv();
    end
`ifdef MEM_ARB_FAIR_EN
    check_eq("fair_d_before_i", 32'(d_before), 32'd2);
    check_eq("fair_i_done",     32'(ic),       32'd1);
    check_eq("fair_d_done",     32'(dc),       32'd3);
`else
    check_eq("strict_i_done", 32'(ic), 32'd0);
    check_eq("strict_d_done", 32'(dc), 32'd4);
`endif
    bus.iREN = 1'b0; bus.dREN = 1'b0; set_ram(c_FREE, 32'h0);
    adv(); adv();

    // ---------------- async reset during DGNT ----------------
    bus.dREN = 1'b1; bus.daddr = 32'h98;
    adv(); set_ram(c_BUSY, 32'h0); settle();
    check_eq("arst_pre_ramREN", 32'(bus.ramREN), 32'd1);
    #1 nRST = 1'b0;
    #1;
    check_eq("arst_ramREN", 32'(bus.ramREN), 32'd0);
    check_eq("arst_ramWEN", 32'(bus.ramWEN), 32'd0);
    check_eq("arst_iwait",  32'(bus.iwait),  32'd1);
    check_eq("arst_dwait",  32'(bus.dwait),  32'd1);
    #1 nRST = 1'b1;
    settle();
    check_eq("arst_idle_ramREN", 32'(bus.ramREN), 32'd0);
    adv(); settle();
    check_eq("arst_regrant_ramREN", 32'(bus.ramREN), 32'd1);
    bus.dREN = 1'b0; set_ram(c_FREE, 32'h0);
    adv(); adv();

    // ---------------- randomized traffic ----------------
    for (int a = 0; a < 16; a++) begin
      gold[a] = $urandom;
      rmem[a] = gold[a];
    end
    i_act = 0; d_act = 0; i_cnt = 0; d_cnt = 0; i_age = 0; d_age = 0;
    lat = $urandom_range(0, 2);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge CLK);
      #1;
      if (!i_act) begin
        if ($urandom_range(0, 2) == 0) begin
          i_act = 1; i_age = 0;
          bus.iREN = 1'b1; bus.iaddr = 32'($urandom_range(0, 15));
        end else begin
          bus.iREN = 1'b0;
        end
      end
      if (!d_act) begin
        if ($urandom_range(0, 2) == 0) begin
          int kind;
          kind = $urandom_range(0, 2);
          d_act = 1; d_age = 0;
          bus.dREN = (kind != 1);
          bus.dWEN = (kind != 0);
          bus.daddr = 32'($urandom_range(0, 15));
          bus.dstore = $urandom;
        end else begin
          bus.dREN = 1'b0; bus.dWEN = 1'b0;
        end
      end
      #1;
      if (bus.ramREN || bus.ramWEN) begin
        if (lat > 0) begin
          lat--;
          set_ram(c_BUSY, $urandom);
        end else begin
          lat = $urandom_range(0, 2);
          if ($urandom_range(0, 7) == 0) set_ram(c_ERROR, $urandom);
          else set_ram(c_ACCESS, bus.ramREN ? rmem[bus.ramaddr[3:0]] : $urandom);
        end
      end else begin
        set_ram(c_FREE, $urandom);
      end

      @(negedge CLK);
      check_eq("rand_en_exclusive", 32'(bus.ramREN & bus.ramWEN), 32'd0);
      check_eq("rand_single_done",  32'(!bus.iwait && !bus.dwait), 32'd0);
      if (!bus.iwait) begin
        check_eq("rand_i_req",   32'(bus.iREN),     32'd1);
        check_eq("rand_i_state", 32'(bus.ramstate), 32'(c_ACCESS));
        check_eq("rand_i_data",  bus.iload,         gold[bus.iaddr[3:0]]);
        i_act = 0; i_cnt++;
      end else begin
        check_eq("rand_iload_idle", bus.iload, 32'd0);
      end
      if (!bus.dwait) begin
        check_eq("rand_d_state", 32'(bus.ramstate), 32'(c_ACCESS));
        if (bus.dWEN) begin
          check_eq("rand_dwr_en",    32'({bus.ramWEN, bus.ramREN}), 32'd2);
          check_eq("rand_dwr_addr",  bus.ramaddr,  bus.daddr);
          check_eq("rand_dwr_store", bus.ramstore, bus.dstore);
          gold[bus.daddr[3:0]] = bus.dstore;
        end else begin
          check_eq("rand_drd_data", bus.dload, gold[bus.daddr[3:0]]);
        end
        d_act = 0; d_cnt++;
      end else begin
        check_eq("rand_dload_idle", bus.dload, 32'd0);
      end
      if (bus.ramWEN && bus.ramstate == c_ACCESS) rmem[bus.ramaddr[3:0]] = bus.ramstore;
      if (i_act) begin
        i_age++;
        if (i_age > 400) begin
          check_eq("rand_i_timeout", 32'(i_age), 32'd0);
          i_act = 0;
        end
      end
      if (d_act) begin
        d_age++;
        if (d_age > 400) begin
          check_eq("rand_d_timeout", 32'(d_age), 32'd0);
          d_act = 0;
        end
      end
    end
    check_eq("rand_i_progress", 32'(i_cnt > 0), 32'd1);
    check_eq("rand_d_progress", 32'(d_cnt > 0), 32'd1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter sitting directly downstream of the instruction cache and the data cache. It merges their independent read and write requests onto the single-port RAM and returns wait/load responses to each cache. It implements a registered grant state machine with data-over-instruction priority, optional anti-starvation for instruction fetches, and retry on RAM error.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while iREN is pending before an instruction grant is forced. Used only with MEM_ARB_FAIR_EN. Range 1..15.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  icache stall; 0 for exactly the cycle iload is valid.
- iload  out  32  instruction word returned to icache.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache stall; 0 for the completion cycle.
- dload  out  32  data word returned to dcache.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- States: IDLE, IGNT, DGNT, RETRY. Reset state is IDLE.
- IDLE: if dREN|dWEN, go to DGNT. Else if iREN, go to IGNT. Else stay in IDLE. RAM enables are 0 in IDLE.
- DGNT: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - When ramstate==ACCESS: dwait=0, dload=ramload, and the next state is IDLE.
  - If dREN and dWEN both drop, go to IDLE without completing.
- IGNT: ramREN=1, ramWEN=0, ramaddr=iaddr.
  - When ramstate==ACCESS: iwait=0, iload=ramload, and the next state is IDLE.
  - If iREN drops (fetch redirect), go to IDLE next cycle.
- ERROR in IGNT or DGNT: go to RETRY and record the granted port.
- RETRY: enables are 0 for one cycle, then return to the recorded grant state and re-issue the request. The requester keeps seeing wait=1.
- If dREN and dWEN are both 1, treat it as a write: ramREN=0, ramWEN=1.
- Requesters must hold address, data and enables stable until their wait deasserts. The arbiter does not latch them; ram outputs are a live mux of the granted port.
- Outputs not in their completion cycle: iwait=1, dwait=1, iload=0, dload=0. Outside grants: ramaddr=0, ramstore=0.

## Timing
- All outputs are combinational from the registered state plus live inputs. There is no combinational path from a request to RAM enables.
- Arbitration latency is 1 cycle: a request seen in IDLE at edge N drives the RAM from cycle N+1.
- Minimum service time is 2 cycles (IDLE, then grant with ramstate==ACCESS).
- Back-to-back requests take at least 1 IDLE cycle between grants.
- Simultaneous i/d requests in IDLE: data wins, unless overridden by the fairness counter.
- Reset mid-transaction:
  - The state machine returns to IDLE immediately and asynchronously.
  - All enables drop the same cycle.
  - The starve counter clears.
- Reset values: iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - A 4-bit starve counter increments on each DGNT completion while iREN is asserted.
  - It clears on any IGNT completion or whenever iREN=0. It saturates at 15.
  - In IDLE, if count>=STARVE_LIMIT and iREN=1, the arbiter goes to IGNT even when a data request is present.
- MEM_ARB_FAIR_EN undefined: no counter; strict data priority.

## Test plan
- Lone fetch: iREN=1, iaddr=0x40, ramstate goes BUSY for 2 cycles then ACCESS with ramload=0xDEADBEEF -> ramREN rises 1 cycle after iREN; iwait=0 and iload=0xDEADBEEF in the ACCESS cycle only; then IDLE.
- Collision: iREN=1 and dWEN=1 in the same cycle, daddr=0x80, dstore=0x1234 -> ramWEN, ramaddr=0x80, ramstore=0x1234 first; dwait pulses low; then a fetch grant; iwait stays 1 throughout the write.
- Error retry: in DGNT with dREN=1, drive ramstate=ERROR once -> 1 cycle with ramREN=0, then ramREN=1 again; dwait stays 1 until ACCESS.
- Redirect: drop iREN midway through a BUSY fetch -> ramREN=0 the next cycle; iwait never pulses low.
- Fairness (MEM_ARB_FAIR_EN, STARVE_LIMIT=2): hold iREN with continuous dREN -> exactly 2 data completions, then 1 instruction completion. Without the macro, no instruction completion occurs.
- Async reset asserted during DGNT -> ramREN=0, ramWEN=0, iwait=1, dwait=1 without waiting for a clock edge; state is IDLE after release.
